// File: rtl/demo_launch_ctrl_pkg.sv
// rtl/demo_launch_ctrl_pkg.sv - shared state and mode encodings for the demo launch controller
//
// Contents:
//   chan_state_t   per-channel handshake FSM states (ST_DELAY is only reachable
//                  when DEMO_LAUNCH_STAGGER_EN is defined)
//   MODE_READ/WRITE  ch_mode encodings
package demo_launch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DELAY     = 3'd4
    } chan_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/demo_launch_ctrl_if.sv
// rtl/demo_launch_ctrl_if.sv - launch handshake bundle between controller and demo masters
//
// Signals (one bit per channel):
//   ch_start  controller -> master  one-cycle launch pulse
//   ch_mode   controller -> master  0 read / 1 write, stable for the whole burst
//   ch_ready  master -> controller  1 = master idle
// Modports: master (controller side), slave (demo_master side).
interface demo_launch_ctrl_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] ch_start;
    logic [NUM_CH-1:0] ch_mode;
    logic [NUM_CH-1:0] ch_ready;

    modport master (output ch_start, output ch_mode, input ch_ready);
    modport slave  (input ch_start, input ch_mode, output ch_ready);
endinterface

// File: rtl/demo_launch_ctrl_chan.sv
// rtl/demo_launch_ctrl_chan.sv - one channel: launch FSM, remaining-burst counter, done counter, overrun flag
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   press            one-cycle debounced button press
//   en, mode_in      channel enable and mode, sampled on press
//   burst_len        transactions per press (0 treated as 1)
//   ready            demo_master idle
//   start            launch pulse (high in LAUNCH while ready)
//   mode             latched mode
//   busy             FSM not in IDLE
//   done_cnt         completed transactions, wraps
//   overrun          sticky, press seen while busy and enabled
// Config: DEMO_LAUNCH_STAGGER_EN adds DELAY_CYCLES of wait before LAUNCH.
module demo_launch_ctrl_chan
    import demo_launch_ctrl_pkg::*;
#(
    parameter int BURST_W      = 4,
    parameter int CNT_WIDTH    = 8
`ifdef DEMO_LAUNCH_STAGGER_EN
    ,
    parameter int DELAY_CYCLES = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 press,
    input  logic                 en,
    input  logic                 mode_in,
    input  logic [BURST_W-1:0]   burst_len,
    input  logic                 ready,
    output logic                 start,
    output logic                 mode,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_cnt,
    output logic                 overrun
);

    chan_state_t        state;
    logic [BURST_W-1:0] rem;

`ifdef DEMO_LAUNCH_STAGGER_EN
    localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES + 1) : 1;
    logic [DLY_W-1:0] dly;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            rem      <= '0;
            mode     <= MODE_READ;
            done_cnt <= '0;
            overrun  <= 1'b0;
`ifdef DEMO_LAUNCH_STAGGER_EN
            dly      <= '0;
`endif
        end else begin
            if (press && en && (state != ST_IDLE))
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (press && en) begin
                        mode <= mode_in;
                        rem  <= (burst_len == '0) ? BURST_W'(1) : burst_len;
`ifdef DEMO_LAUNCH_STAGGER_EN
                        if (DELAY_CYCLES == 0) begin
                            state <= ST_LAUNCH;
                        end else begin
                            dly   <= DLY_W'(DELAY_CYCLES);
                            state <= ST_DELAY;
                        end
`else
                        state <= ST_LAUNCH;
`endif
                    end
                end
`ifdef DEMO_LAUNCH_STAGGER_EN
                // dly counts the cycles spent here; leave when the last one is used
                ST_DELAY: begin
                    dly <= dly - 1'b1;
                    if (dly <= DLY_W'(1))
                        state <= ST_LAUNCH;
                end
`endif
                ST_LAUNCH: begin
                    if (ready)
                        state <= ST_WAIT_BUSY;
                end
                // master needs a cycle to drop ready after the pulse
                ST_WAIT_BUSY: begin
                    if (!ready)
                        state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (ready) begin
                        done_cnt <= done_cnt + 1'b1;
                        rem      <= rem - 1'b1;
                        state    <= (rem == BURST_W'(1)) ? ST_IDLE : ST_LAUNCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // pulse is tied to the LAUNCH cycle in which the master is seen ready
    assign start = (state == ST_LAUNCH) && ready;
    assign busy  = (state != ST_IDLE);

endmodule

// File: rtl/demo_launch_ctrl.sv
// rtl/demo_launch_ctrl.sv - button sync/debounce and per-channel burst launch for the demo masters
//
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   start_n       raw active-low push button (asynchronous)
//   ch_en         channel enables, sampled on press
//   ch_mode_in    per-channel mode (0 read / 1 write), sampled on press
//   burst_len     transactions per press per channel, 0 treated as 1
//   ch_busy       channel FSM not IDLE
//   done_cnt      completed transactions, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   overrun       sticky per channel: press while enabled channel busy
//   all_idle      every channel FSM in IDLE
//   bus           demo_launch_ctrl_if.master: ch_start, ch_mode out, ch_ready in
// Config macro: DEMO_LAUNCH_STAGGER_EN - channel i waits i*STAGGER_CYCLES after a press before LAUNCH.
module demo_launch_ctrl
    import demo_launch_ctrl_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BURST_W         = 4,
    parameter int CNT_WIDTH       = 8,
    parameter int STAGGER_CYCLES  = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start_n,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [NUM_CH-1:0]           ch_mode_in,
    input  logic [BURST_W-1:0]          burst_len,
    output logic [NUM_CH-1:0]           ch_busy,
    output logic [NUM_CH*CNT_WIDTH-1:0] done_cnt,
    output logic [NUM_CH-1:0]           overrun,
    output logic                        all_idle,
    demo_launch_ctrl_if.master          bus
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic           sync1, sync2;
    logic           deb, deb_d;
    logic [DBW-1:0] db_cnt;
    logic           press;

    logic [NUM_CH-1:0] chan_start;
    logic [NUM_CH-1:0] chan_mode;

    // Button levels reset to released so no press is seen coming out of reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            deb    <= 1'b1;
            deb_d  <= 1'b1;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= start_n;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            // any cycle agreeing with the debounced level restarts the count
            if (sync2 == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                deb    <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        demo_launch_ctrl_chan #(
            .BURST_W      (BURST_W),
            .CNT_WIDTH    (CNT_WIDTH)
`ifdef DEMO_LAUNCH_STAGGER_EN
            ,
            .DELAY_CYCLES (i * STAGGER_CYCLES)
`endif
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .press     (press),
            .en        (ch_en[i]),
            .mode_in   (ch_mode_in[i]),
            .burst_len (burst_len),
            .ready     (bus.ch_ready[i]),
            .start     (chan_start[i]),
            .mode      (chan_mode[i]),
            .busy      (ch_busy[i]),
            .done_cnt  (done_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
            .overrun   (overrun[i])
        );
    end

    assign bus.ch_start = chan_start;
    assign bus.ch_mode  = chan_mode;
    assign all_idle     = ~|ch_busy;

endmodule

// File: tb/tb_demo_launch_ctrl.sv
// tb/tb_demo_launch_ctrl.sv - scoreboard bench for demo_launch_ctrl with a delayed-ready master model
module tb_demo_launch_ctrl;
    import demo_launch_ctrl_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DEB    = 16;
    localparam int BW     = 4;
    localparam int CW     = 8;
    localparam int STAG   = 4;
    // clean edge -> press is 2+DEB+1 cycles, plus one cycle to enter LAUNCH
    localparam int LAT0   = 2 + DEB + 1 + 1;
`ifdef DEMO_LAUNCH_STAGGER_EN
    localparam int LAT1   = LAT0 + STAG;
`else
    localparam int LAT1   = LAT0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_n = 1'b1;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [NUM_CH-1:0] ch_mode_in = '0;
    logic [BW-1:0]     burst_len = '0;
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH*CW-1:0] done_cnt;
    logic [NUM_CH-1:0] overrun;
    logic              all_idle;

    logic [NUM_CH-1:0] model_rdy = '1;
    logic [NUM_CH-1:0] force_low = '0;
    logic [NUM_CH-1:0] drop_pend = '0;
    int                low_cnt [NUM_CH];

    demo_launch_ctrl_if #(.NUM_CH(NUM_CH)) bus ();
    assign bus.ch_ready = model_rdy & ~force_low;

    demo_launch_ctrl #(
        .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .BURST_W(BW),
        .CNT_WIDTH(CW), .STAGGER_CYCLES(STAG)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_n    (start_n),
        .ch_en      (ch_en),
        .ch_mode_in (ch_mode_in),
        .burst_len  (burst_len),
        .ch_busy    (ch_busy),
        .done_cnt   (done_cnt),
        .overrun    (overrun),
        .all_idle   (all_idle),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic exp_q0[$];
    logic exp_q1[$];
    logic exp_m;
    int   start_cnt [NUM_CH];
    int   first_start [NUM_CH];
    int   exp_done [NUM_CH];
    logic [NUM_CH-1:0] exp_overrun;

    // Monitor and master model: ready drops the cycle after a start and
    // returns 10 cycles later. Every observed start is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rstn) begin
            model_rdy = '1;
            drop_pend = '0;
            for (int i = 0; i < NUM_CH; i++) low_cnt[i] = 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.ch_start[i]) begin
                    start_cnt[i]++;
                    if (first_start[i] < 0) first_start[i] = cyc;
                    tests++;
                    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                        fails++;
                        $display("FAIL start_unexpected ch%0d at cycle %0d: got pulse, required none", i, cyc);
                    end else begin
                        exp_m = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (bus.ch_mode[i] !== exp_m) begin
                            fails++;
                            $display("FAIL start_mode ch%0d: got %b, required %b", i, bus.ch_mode[i], exp_m);
                        end
                    end
                    drop_pend[i] = 1'b1;
                end else if (drop_pend[i]) begin
                    drop_pend[i] = 1'b0;
                    model_rdy[i] = 1'b0;
                    low_cnt[i]   = 10;
                end else if (low_cnt[i] > 0) begin
                    low_cnt[i]--;
                    if (low_cnt[i] == 0) model_rdy[i] = 1'b1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_sb();
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            start_cnt[i]   = 0;
            first_start[i] = -1;
            exp_done[i]    = 0;
        end
        exp_overrun = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        start_n = 1'b1;
        force_low = '0;
        cycles(3);
        clear_sb();
        rstn = 1'b1;
        cycles(2);
    endtask

    // Sets up the press inputs and records what the DUT should do with them.
    task automatic expect_press(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] mode,
                                input logic [BW-1:0] bl, input logic [NUM_CH-1:0] busy_mask);
        int n;
        ch_en = en;
        ch_mode_in = mode;
        burst_len = bl;
        n = (bl == 0) ? 1 : int'(bl);
        for (int i = 0; i < NUM_CH; i++) begin
            if (en[i] && busy_mask[i]) begin
                exp_overrun[i] = 1'b1;
            end else if (en[i]) begin
                exp_done[i] += n;
                for (int k = 0; k < n; k++) begin
                    if (i == 0) exp_q0.push_back(mode[i]);
                    else        exp_q1.push_back(mode[i]);
                end
            end
        end
    endtask

    task automatic press_low(input int n);
        start_n = 1'b0;
        cycles(n);
    endtask

    task automatic press_release();
        start_n = 1'b1;
        cycles(25);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while (!(all_idle && bus.ch_ready == '1 && force_low == '0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= limit) begin
            fails++;
            $display("FAIL %s_idle_timeout: all_idle=%b ch_busy=%b after %0d cycles, required idle", tag, all_idle, ch_busy, limit);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < NUM_CH; i++) begin
            tests++;
            if (done_cnt[i*CW +: CW] !== CW'(exp_done[i])) begin
                fails++;
                $display("FAIL %s_done_cnt ch%0d: got %0d, required %0d", tag, i, done_cnt[i*CW +: CW], exp_done[i]);
            end
        end
        tests++;
        if (overrun !== exp_overrun) begin
            fails++;
            $display("FAIL %s_overrun: got %b, required %b", tag, overrun, exp_overrun);
        end
        tests++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            fails++;
            $display("FAIL %s_missing_starts: got %0d/%0d pending, required 0/0", tag, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (bus.ch_start !== '0 || bus.ch_mode !== '0 || ch_busy !== '0) begin
            fails++;
            $display("FAIL %s_ctrl: start=%b mode=%b busy=%b, required 0/0/0", tag, bus.ch_start, bus.ch_mode, ch_busy);
        end
        tests++;
        if (done_cnt !== '0 || overrun !== '0 || all_idle !== 1'b1) begin
            fails++;
            $display("FAIL %s_status: done=%h overrun=%b all_idle=%b, required 0/0/1", tag, done_cnt, overrun, all_idle);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_debounce();
        int t0;
        do_reset();
        ch_en = 2'b11;
        burst_len = 4'd1;
        ch_mode_in = 2'b00;
        start_n = 1'b0;
        cycles(5);
        start_n = 1'b1;
        cycles(40);
        tests++;
        if (ch_busy !== 2'b00 || start_cnt[0] + start_cnt[1] != 0) begin
            fails++;
            $display("FAIL glitch_press: busy=%b starts=%0d, required 00 and 0", ch_busy, start_cnt[0] + start_cnt[1]);
        end
        expect_press(2'b11, 2'b00, 4'd1, 2'b00);
        t0 = cyc;
        press_low(40);
        tests++;
        if (first_start[0] - t0 != LAT0) begin
            fails++;
            $display("FAIL press_latency ch0: got %0d, required %0d", first_start[0] - t0, LAT0);
        end
        tests++;
        if (first_start[1] - t0 != LAT1) begin
            fails++;
            $display("FAIL press_latency ch1: got %0d, required %0d", first_start[1] - t0, LAT1);
        end
        press_release();
        wait_idle("debounce", 200);
        check_state("debounce");
    endtask

    task automatic test_burst();
        do_reset();
        expect_press(2'b11, 2'b00, 4'd3, 2'b00);
        press_low(25);
        press_release();
        wait_idle("burst", 300);
        check_state("burst");
        tests++;
        if (start_cnt[0] != 3 || start_cnt[1] != 3) begin
            fails++;
            $display("FAIL burst_starts: got %0d,%0d, required 3,3", start_cnt[0], start_cnt[1]);
        end
    endtask

    task automatic test_single_mode();
        do_reset();
        expect_press(2'b01, 2'b01, 4'd0, 2'b00);
        press_low(25);
        press_release();
        wait_idle("single", 200);
        check_state("single");
        tests++;
        if (bus.ch_mode[0] !== MODE_WRITE || start_cnt[0] != 1 || start_cnt[1] != 0) begin
            fails++;
            $display("FAIL single_launch: mode0=%b starts=%0d,%0d, required 1 and 1,0", bus.ch_mode[0], start_cnt[0], start_cnt[1]);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        expect_press(2'b01, 2'b00, 4'd15, 2'b00);
        press_low(25);
        press_release();
        tests++;
        if (ch_busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL overrun_precond: busy0=%b, required 1", ch_busy[0]);
        end
        // mode flips on the ignored press; latched mode must not follow it
        expect_press(2'b01, 2'b01, 4'd15, 2'b01);
        press_low(25);
        press_release();
        wait_idle("overrun", 400);
        check_state("overrun");
        cycles(10);
        tests++;
        if (overrun !== 2'b01 || bus.ch_mode[0] !== MODE_READ) begin
            fails++;
            $display("FAIL overrun_sticky: overrun=%b mode0=%b, required 01 and 0", overrun, bus.ch_mode[0]);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        tests++;
        if (overrun !== 2'b00) begin
            fails++;
            $display("FAIL overrun_clear: got %b, required 00", overrun);
        end
        rstn = 1'b1;
    endtask

    task automatic test_ready_hold();
        do_reset();
        force_low = 2'b10;
        expect_press(2'b11, 2'b10, 4'd1, 2'b00);
        press_low(25);
        cycles(20);
        tests++;
        if (ch_busy[1] !== 1'b1 || start_cnt[1] != 0) begin
            fails++;
            $display("FAIL hold_launch: busy1=%b starts1=%0d, required 1 and 0", ch_busy[1], start_cnt[1]);
        end
        force_low = '0;
        press_release();
        wait_idle("hold", 200);
        check_state("hold");
        tests++;
        if (start_cnt[1] != 1) begin
            fails++;
            $display("FAIL hold_single_pulse: got %0d, required 1", start_cnt[1]);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int s0, s1;
        do_reset();
        expect_press(2'b11, 2'b00, 4'd3, 2'b00);
        press_low(25);
        start_n = 1'b1;
        while (!(ch_busy[0] && !bus.ch_ready[0]) && k < 50) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 50) begin
            fails++;
            $display("FAIL midreset_wait_done: busy0=%b ready0=%b, required 1/0", ch_busy[0], bus.ch_ready[0]);
        end
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q0.delete();
        exp_q1.delete();
        s0 = start_cnt[0];
        s1 = start_cnt[1];
        rstn = 1'b1;
        cycles(40);
        tests++;
        if (start_cnt[0] != s0 || start_cnt[1] != s1 || ch_busy !== 2'b00) begin
            fails++;
            $display("FAIL midreset_quiet: starts %0d,%0d busy=%b, required %0d,%0d and 00", start_cnt[0], start_cnt[1], ch_busy, s0, s1);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) low_cnt[i] = 0;
        clear_sb();
        test_reset();
        test_debounce();
        test_burst();
        test_single_mode();
        test_overrun();
        test_ready_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
